// File: rtl/ddr_read_ctrl.sv
// Single-burst DDR SDRAM read controller: ACTIVE -> READ -> capture BL_CYCLES beats -> PRECHARGE.
// Define DDR_READ_REFRESH_EN to add the periodic AUTO REFRESH scheduler (counter + WAIT_RFC).
module ddr_read_ctrl #(
  parameter int tRCD      = 3,
  parameter int CL        = 2,
  parameter int PHY_LAT   = 1,
  parameter int BL_CYCLES = 1,
  parameter int tRP       = 3,
  parameter int tRFC      = 11,
  parameter int tREFI     = 1036
) (
  input  logic        clk133,
  input  logic        rst,
  input  logic        initDone,
  input  logic        rdReq,
  input  logic [23:0] rdAddr,
  output logic        rdAck,
  output logic [31:0] rdData,
  output logic        rdValid,
  output logic        busy,
  input  logic [31:0] phyData,
  output logic [12:0] sd_A,
  output logic [1:0]  sd_BA,
  output logic        sd_RAS,
  output logic        sd_CAS,
  output logic        sd_WE,
  output logic        sd_CS
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int DLY_MAX = max2(max2(max2(tRCD, CL + PHY_LAT), max2(BL_CYCLES, tRP)), tRFC);
  localparam int CW      = $clog2(DLY_MAX + 1);

  // WAIT_RP / WAIT_RFC preload (t - 2) so the controller is back in IDLE exactly t cycles later.
  localparam bit CFG_OK = (BL_CYCLES == 1 || BL_CYCLES == 2 || BL_CYCLES == 4) &&
                          (tRCD >= 1) && (CL + PHY_LAT >= 1) && (tRP >= 2) &&
                          (tRFC >= 2) && (tREFI >= 2);
  if (!CFG_OK) begin : g_cfg_check
    $error("ddr_read_ctrl: unsupported timing parameter set");
  end

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RCD,
    WAIT_DATA,
    CAPTURE,
    WAIT_RP
`ifdef DDR_READ_REFRESH_EN
    , WAIT_RFC
`endif
  } state_t;

  typedef enum logic [2:0] {
    CMD_REF  = 3'b001,
    CMD_PRE  = 3'b010,
    CMD_ACT  = 3'b011,
    CMD_READ = 3'b101,
    CMD_NOP  = 3'b111
  } cmd_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [1:0]    bank_q;
  logic [8:0]    col_q;
  logic          req_go, ref_go;
  cmd_t          cmd_d;
  logic [12:0]   a_d;
  logic [1:0]    ba_d;
  logic          ack_d, capture;

`ifdef DDR_READ_REFRESH_EN
  localparam int RW = $clog2(tREFI);

  logic [RW-1:0] ref_cnt;
  logic          ref_pending, ref_wrap;

  assign ref_wrap = initDone && (ref_cnt == RW'(tREFI - 1));
  assign ref_go   = (state == IDLE) && initDone && ref_pending;

  always_ff @(posedge clk133) begin
    if (rst) begin
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
    end else begin
      if (initDone) ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
      // A fresh interval outranks the clear so an expiry landing on the refresh edge is kept.
      if (ref_wrap)    ref_pending <= 1'b1;
      else if (ref_go) ref_pending <= 1'b0;
    end
  end
`else
  assign ref_go = 1'b0;
`endif

  assign req_go = (state == IDLE) && initDone && rdReq && !ref_go;

  always_ff @(posedge clk133) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    // NOTE: defaults first; any path that skips an assignment would otherwise infer a latch.
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (req_go) begin
          state_next = WAIT_RCD;
          cnt_next   = CW'(tRCD - 1);
        end
`ifdef DDR_READ_REFRESH_EN
        else if (ref_go) begin
          state_next = WAIT_RFC;
          cnt_next   = CW'(tRFC - 2);
        end
`endif
      end
      WAIT_RCD: begin
        if (cnt == '0) begin
          state_next = WAIT_DATA;
          cnt_next   = CW'(CL + PHY_LAT - 1);
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      WAIT_DATA: begin
        if (cnt == '0) begin
          state_next = CAPTURE;
          cnt_next   = CW'(BL_CYCLES - 1);
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      CAPTURE: begin
        if (cnt == '0) begin
          state_next = WAIT_RP;
          cnt_next   = CW'(tRP - 2);
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      WAIT_RP: begin
        if (cnt == '0) state_next = IDLE;
        else           cnt_next   = cnt - 1'b1;
      end
`ifdef DDR_READ_REFRESH_EN
      WAIT_RFC: begin
        if (cnt == '0) state_next = IDLE;
        else           cnt_next   = cnt - 1'b1;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Beat 0 is taken on the last WAIT_DATA edge; CAPTURE takes the rest, then closes the row.
  always_comb begin
    cmd_d   = CMD_NOP;
    a_d     = '0;
    ba_d    = '0;
    ack_d   = 1'b0;
    capture = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_go) begin
          cmd_d = CMD_ACT;
          a_d   = rdAddr[23:11];
          ba_d  = rdAddr[10:9];
          ack_d = 1'b1;
        end else if (ref_go) begin
          cmd_d = CMD_REF;
        end
      end
      WAIT_RCD: begin
        if (cnt == '0) begin
          cmd_d = CMD_READ;
          a_d   = {4'b0000, col_q};
          ba_d  = bank_q;
        end
      end
      WAIT_DATA: capture = (cnt == '0);
      CAPTURE: begin
        if (cnt == '0) begin
          cmd_d = CMD_PRE;
          a_d   = 13'h0400;
          ba_d  = bank_q;
        end else begin
          capture = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk133) begin
    if (rst) begin
      sd_CS                    <= 1'b1;
      {sd_RAS, sd_CAS, sd_WE}  <= CMD_NOP;
      sd_A                     <= '0;
      sd_BA                    <= '0;
      rdAck                    <= 1'b0;
      rdValid                  <= 1'b0;
      rdData                   <= '0;
      busy                     <= 1'b0;
      bank_q                   <= '0;
      col_q                    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      sd_CS                    <= 1'b0;
      {sd_RAS, sd_CAS, sd_WE}  <= cmd_d;
      sd_A                     <= a_d;
      sd_BA                    <= ba_d;
      rdAck                    <= ack_d;
      rdValid                  <= capture;
      busy                     <= (state_next != IDLE);
      if (capture) rdData <= phyData;
      if (ack_d) begin
        bank_q <= rdAddr[10:9];
        col_q  <= rdAddr[8:0];
      end
    end
  end

endmodule

// File: tb/tb_ddr_read_ctrl.sv
// Bench for ddr_read_ctrl: two instances (BL_CYCLES 1 and 4) against a timeline reference model.
// Build with DDR_READ_REFRESH_EN to exercise refresh with a short tREFI.
module tb_ddr_read_ctrl;

  localparam int T_RCD = 3;
  localparam int T_CL  = 2;
  localparam int T_PHY = 1;
  localparam int T_RP  = 3;
  localparam int T_RFC = 11;
`ifdef DDR_READ_REFRESH_EN
  localparam int T_REFI = 20;
`else
  localparam int T_REFI = 1036;
`endif

  localparam logic [2:0] C_NOP  = 3'b111;
  localparam logic [2:0] C_ACT  = 3'b011;
  localparam logic [2:0] C_READ = 3'b101;
  localparam logic [2:0] C_PRE  = 3'b010;
  localparam logic [2:0] C_REF  = 3'b001;

  logic        clk133 = 1'b0;
  logic        rst, initDone, rdReq;
  logic [23:0] rdAddr;
  logic [31:0] phyData;

  logic        rd_ack   [2];
  logic [31:0] rd_data  [2];
  logic        rd_valid [2];
  logic        busy_o   [2];
  logic [12:0] sd_a     [2];
  logic [1:0]  sd_ba    [2];
  logic        sd_ras   [2];
  logic        sd_cas   [2];
  logic        sd_we    [2];
  logic        sd_cs    [2];

  always #5 clk133 = ~clk133;

  ddr_read_ctrl #(
    .tRCD(T_RCD), .CL(T_CL), .PHY_LAT(T_PHY), .BL_CYCLES(1),
    .tRP(T_RP), .tRFC(T_RFC), .tREFI(T_REFI)
  ) dut_bl1 (
    .clk133(clk133), .rst(rst), .initDone(initDone), .rdReq(rdReq), .rdAddr(rdAddr),
    .rdAck(rd_ack[0]), .rdData(rd_data[0]), .rdValid(rd_valid[0]), .busy(busy_o[0]),
    .phyData(phyData), .sd_A(sd_a[0]), .sd_BA(sd_ba[0]), .sd_RAS(sd_ras[0]),
    .sd_CAS(sd_cas[0]), .sd_WE(sd_we[0]), .sd_CS(sd_cs[0])
  );

  ddr_read_ctrl #(
    .tRCD(T_RCD), .CL(T_CL), .PHY_LAT(T_PHY), .BL_CYCLES(4),
    .tRP(T_RP), .tRFC(T_RFC), .tREFI(T_REFI)
  ) dut_bl4 (
    .clk133(clk133), .rst(rst), .initDone(initDone), .rdReq(rdReq), .rdAddr(rdAddr),
    .rdAck(rd_ack[1]), .rdData(rd_data[1]), .rdValid(rd_valid[1]), .busy(busy_o[1]),
    .phyData(phyData), .sd_A(sd_a[1]), .sd_BA(sd_ba[1]), .sd_RAS(sd_ras[1]),
    .sd_CAS(sd_cas[1]), .sd_WE(sd_we[1]), .sd_CS(sd_cs[1])
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int bl_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  // Expected post-edge outputs derived from the edge at which the current request was accepted.
  typedef struct {
    longint      free_at;
    longint      act_at;
    bit          live;
    logic [12:0] row;
    logic [1:0]  bank;
    logic [8:0]  col;
    int          ticks;
    bit          pending;
    logic [2:0]  cmd;
    logic [12:0] a;
    logic [1:0]  ba;
    logic        cs, ack, valid, busy;
    logic [31:0] data;
    int          a_kind;
  } model_t;

  model_t m [2];
  longint edge_n = 0;

  function automatic model_t step(input model_t s, input int bl, input longint n);
    longint d;
    int     base;
    base     = T_RCD + T_CL + T_PHY;
    s.cmd    = C_NOP;
    s.ack    = 1'b0;
    s.valid  = 1'b0;
    s.a_kind = 0;
    if (rst) begin
      s.live    = 1'b0;
      s.free_at = n + 1;
      s.ticks   = 0;
      s.pending = 1'b0;
      s.cs      = 1'b1;
      s.a       = '0;
      s.ba      = '0;
      s.data    = '0;
      s.busy    = 1'b0;
      s.a_kind  = 1;
      return s;
    end
    s.cs = 1'b0;
    if (n >= s.free_at && initDone && s.pending) begin
      s.cmd     = C_REF;
      s.pending = 1'b0;
      s.live    = 1'b0;
      s.free_at = n + T_RFC;
    end else if (n >= s.free_at && initDone && rdReq) begin
      s.cmd     = C_ACT;
      s.ack     = 1'b1;
      s.live    = 1'b1;
      s.act_at  = n;
      s.row     = rdAddr[23:11];
      s.bank    = rdAddr[10:9];
      s.col     = rdAddr[8:0];
      s.a       = rdAddr[23:11];
      s.ba      = rdAddr[10:9];
      s.a_kind  = 1;
      s.free_at = n + base + bl + T_RP;
    end else if (s.live) begin
      d = n - s.act_at;
      if (d == T_RCD) begin
        s.cmd    = C_READ;
        s.a      = {4'b0000, s.col};
        s.ba     = s.bank;
        s.a_kind = 1;
      end else if (d >= base && d < base + bl) begin
        s.valid = 1'b1;
        s.data  = phyData;
      end else if (d == base + bl) begin
        s.cmd    = C_PRE;
        s.a_kind = 2;
      end
    end
    s.busy = (n + 1 < s.free_at);
`ifdef DDR_READ_REFRESH_EN
    if (initDone) begin
      s.ticks++;
      if (s.ticks % T_REFI == 0) s.pending = 1'b1;
    end
`endif
    return s;
  endfunction

  task automatic compare(input int i);
    string s;
    s = $sformatf("bl%0d", bl_of(i));
    check({s, "_cmd"},   32'({sd_ras[i], sd_cas[i], sd_we[i]}), 32'(m[i].cmd));
    check({s, "_cs"},    32'(sd_cs[i]),    32'(m[i].cs));
    check({s, "_ack"},   32'(rd_ack[i]),   32'(m[i].ack));
    check({s, "_valid"}, 32'(rd_valid[i]), 32'(m[i].valid));
    check({s, "_busy"},  32'(busy_o[i]),   32'(m[i].busy));
    check({s, "_data"},  rd_data[i],       m[i].data);
    if (m[i].a_kind == 1) begin
      check({s, "_addr"}, 32'(sd_a[i]),  32'(m[i].a));
      check({s, "_bank"}, 32'(sd_ba[i]), 32'(m[i].ba));
    end else if (m[i].a_kind == 2) begin
      check({s, "_a10"}, 32'(sd_a[i][10]), 32'd1);
    end
  endtask

  // Model and DUT both see inputs at the posedge; outputs are compared at the following negedge.
  task automatic cycle();
    @(posedge clk133);
    for (int i = 0; i < 2; i++) m[i] = step(m[i], bl_of(i), edge_n);
    edge_n++;
    @(negedge clk133);
    for (int i = 0; i < 2; i++) compare(i);
  endtask

  initial begin
    longint last_act [2];
    rst      = 1'b1;
    initDone = 1'b0;
    rdReq    = 1'b0;
    rdAddr   = '0;
    phyData  = '0;
    repeat (3) cycle();
    rst = 1'b0;

    // Requests while init is incomplete must be ignored.
    for (int k = 0; k < 40; k++) begin
      rdReq   = 1'($urandom);
      rdAddr  = 24'($urandom);
      phyData = $urandom;
      cycle();
    end

    // Reference transfer at row 0x15, bank 0, column 5.
    initDone = 1'b1;
    rdReq    = 1'b1;
    rdAddr   = 24'h00A805;
    phyData  = '0;
    for (int k = 0; k < 16; k++) begin
      cycle();
      if (rd_ack[0] || rd_ack[1]) rdReq = 1'b0;
      phyData = (k == 5) ? 32'h5555AAAA : (k >= 6 && k <= 8) ? 32'(k - 4) : 32'h0;
    end

    // Request held high: back-to-back ACTIVEs at the full turnaround spacing.
    last_act[0] = -1;
    last_act[1] = -1;
    rdReq = 1'b1;
    for (int k = 0; k < 80; k++) begin
      rdAddr  = 24'($urandom);
      phyData = $urandom;
      cycle();
`ifndef DDR_READ_REFRESH_EN
      for (int i = 0; i < 2; i++) begin
        if ({sd_ras[i], sd_cas[i], sd_we[i]} == C_ACT) begin
          if (last_act[i] >= 0)
            check($sformatf("bl%0d_act_gap", bl_of(i)), 32'(edge_n - last_act[i]),
                  32'(T_RCD + T_CL + T_PHY + bl_of(i) + T_RP));
          last_act[i] = edge_n;
        end
      end
`endif
    end
    rdReq = 1'b0;
    repeat (20) cycle();

    // Reset four edges into a read, then a fresh request.
    rdReq  = 1'b1;
    rdAddr = 24'h3F_FE_12;
    cycle();
    rdReq = 1'b0;
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    rst    = 1'b0;
    rdReq  = 1'b1;
    rdAddr = 24'h12_34_56;
    for (int k = 0; k < 20; k++) begin
      phyData = $urandom;
      cycle();
      if (rd_ack[0] || rd_ack[1]) rdReq = 1'b0;
    end

    // Random traffic with occasional reset and init drop.
    for (int k = 0; k < 4000; k++) begin
      if (rd_ack[0] || rd_ack[1]) rdReq = 1'b0;
      else if ($urandom_range(0, 2) == 0) rdReq = ~rdReq;
      rdAddr   = 24'($urandom);
      phyData  = $urandom;
      rst      = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 149) == 0) initDone = ~initDone;
      cycle();
    end
    rst      = 1'b0;
    initDone = 1'b1;
    rdReq    = 1'b0;
    repeat (20) cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
